muldiv_seq: RTL

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_signfix.sv | 16 +
 rtl/muldiv_seq.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
//   MD_*     : op_i encodings
//   state_e  : control FSM states (also exposed on dbg_state_o)
//   helpers  : decode of op_i into divide / signed flags
package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate. Used both to take the magnitude of a
// signed operand (neg_i = sign bit) and to re-apply a sign to a result.
//   val_i [N-1:0] : value in
//   neg_i         : 1 -> output is -val_i, 0 -> output is val_i
//   val_o [N-1:0] : value out
module muldiv_signfix #(
  parameter int N = 32
) (
  input  logic [N-1:0] val_i,
  input  logic         neg_i,
  output logic [N-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + {{(N-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/muldiv_seq.sv
// Sequential radix-2 multiply / restoring divide unit.
//   clk, rst      : clock, asynchronous active-high reset
//   start_i       : request; accepted in IDLE when annul_i is low
//   op_i          : MD_MULT / MD_MULTU / MD_DIV / MD_DIVU
//   opa_i, opb_i  : multiplicand/dividend, multiplier/divisor
//   annul_i       : abort; wins over start_i, kills BUSY/DONE
//   busy_o        : operation in progress (BUSY or DONE)
//   ready_o       : one-cycle completion pulse
//   result_o      : {hi, lo} product or {remainder, quotient}
//   div_zero_o    : last completed divide had a zero divisor
//   dbg_state_o   : current FSM state
// Handshake: a request is taken on the rising edge where the FSM is IDLE,
// start_i=1 and annul_i=0; operands are captured on that edge only. The
// result is valid (and stays valid) from the cycle in which ready_o is high.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_zero_o,
  output state_e             dbg_state_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int W2 = 2 * WIDTH;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [W2:0]     work_q, work_d;
  logic [WIDTH-1:0] mag_q;     // multiplicand magnitude (mul) or divisor magnitude (div)
  logic            is_div_q;
  logic            dz_q;
  logic            neg_lo_q;   // sign of product / quotient
  logic            neg_hi_q;   // sign of remainder
  logic            ready_q;
  logic [W2-1:0]   result_q;
  logic            div_zero_q;

  // Operand conditioning
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = op_is_signed(op_i) & opa_i[WIDTH-1];
  assign b_neg = op_is_signed(op_i) & opb_i[WIDTH-1];

  muldiv_signfix #(.N(WIDTH)) u_fix_a (.val_i(opa_i), .neg_i(a_neg), .val_o(a_mag));
  muldiv_signfix #(.N(WIDTH)) u_fix_b (.val_i(opb_i), .neg_i(b_neg), .val_o(b_mag));

  // One iteration step. Mul: work = {carry, hi, lo}, add into hi when lo[0]
  // is set, then shift right. Div: work = {rem(W+1), dividend/quotient(W)},
  // shift left one bit and subtract the divisor if it fits.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rem;
  logic [WIDTH+1:0] div_diff;

  always_comb begin
    mul_sum  = work_q[W2:WIDTH] + (work_q[0] ? {1'b0, mag_q} : '0);
    div_rem  = {work_q[W2-1:WIDTH], work_q[WIDTH-1]};
    div_diff = {1'b0, div_rem} - {2'b00, mag_q};
    work_d   = {1'b0, mul_sum, work_q[WIDTH-1:1]};
    if (is_div_q) begin
      if (div_diff[WIDTH+1]) work_d = {div_rem, work_q[WIDTH-2:0], 1'b0};
      else                   work_d = {div_diff[WIDTH:0], work_q[WIDTH-2:0], 1'b1};
    end
  end

  // Result sign correction
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic [W2-1:0]    done_result;

  muldiv_signfix #(.N(W2))    u_fix_p (.val_i(work_q[W2-1:0]),     .neg_i(neg_lo_q), .val_o(prod_fix));
  muldiv_signfix #(.N(WIDTH)) u_fix_q (.val_i(work_q[WIDTH-1:0]),  .neg_i(neg_lo_q), .val_o(quo_fix));
  muldiv_signfix #(.N(WIDTH)) u_fix_r (.val_i(work_q[W2-1:WIDTH]), .neg_i(neg_hi_q), .val_o(rem_fix));

  // A zero-divisor request loads the final pattern straight into work_q.
  assign done_result = dz_q     ? work_q[W2-1:0] :
                       is_div_q ? {rem_fix, quo_fix} : prod_fix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      mag_q      <= '0;
      is_div_q   <= 1'b0;
      dz_q       <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      ready_q    <= 1'b0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i && !annul_i) begin
            is_div_q <= op_is_div(op_i);
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= a_neg;
            cnt_q    <= CW'(WIDTH);
            dz_q     <= 1'b0;
            state_q  <= ST_BUSY;
            if (op_is_div(op_i)) begin
              mag_q  <= b_mag;
              work_q <= {{(WIDTH+1){1'b0}}, a_mag};
              if (opb_i == '0) begin
                dz_q    <= 1'b1;
                cnt_q   <= '0;
                work_q  <= {1'b0, opa_i, {WIDTH{1'b1}}};
                state_q <= ST_DONE;
              end
            end else begin
              mag_q  <= a_mag;
              work_q <= {{(WIDTH+1){1'b0}}, b_mag};
            end
          end
        end
        ST_BUSY: begin
          if (annul_i) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            work_q <= work_d;
            cnt_q  <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!annul_i) begin
            result_q   <= done_result;
            div_zero_q <= dz_q;
            ready_q    <= 1'b1;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign ready_o     = ready_q;
  assign result_o    = result_q;
  assign div_zero_o  = div_zero_q;
  assign dbg_state_o = state_q;

endmodule
